// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
// The optional lock-loss counter is enabled with PLL_RST_CTRL_LOSS_COUNT_EN.
package pll_rst_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } pll_rst_state_t;

   localparam int DEF_RST_PULSE_CYC    = 16;
   localparam int DEF_LOCK_STABLE_CYC  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
   localparam int DEF_MAX_RETRY        = 3;
   localparam int DEF_SYNC_STAGES      = 2;
   localparam int LOSS_CNT_W           = 16;

   // Width able to hold 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// Control/status bundle between the reset sequencer and its environment.
// loss_count exists only when PLL_RST_CTRL_LOSS_COUNT_EN is defined.
interface pll_reset_ctrl_if
   import pll_rst_ctrl_pkg::*;
#(
   parameter int MAX_RETRY = DEF_MAX_RETRY
);
   localparam int RW = cnt_w(MAX_RETRY);

   logic          soft_rst_req;
   logic          pll_locked_in;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          ready;
   logic          lock_lost;
   logic          fail;
   logic [RW-1:0] retry_cnt;
`ifdef PLL_RST_CTRL_LOSS_COUNT_EN
   logic [LOSS_CNT_W-1:0] loss_count;

   modport master (output soft_rst_req, pll_locked_in,
                   input  pll_rst, sys_rst_n, ready, lock_lost, fail, retry_cnt, loss_count);
   modport slave  (input  soft_rst_req, pll_locked_in,
                   output pll_rst, sys_rst_n, ready, lock_lost, fail, retry_cnt, loss_count);
`else
   modport master (output soft_rst_req, pll_locked_in,
                   input  pll_rst, sys_rst_n, ready, lock_lost, fail, retry_cnt);
   modport slave  (input  soft_rst_req, pll_locked_in,
                   output pll_rst, sys_rst_n, ready, lock_lost, fail, retry_cnt);
`endif
endinterface

// File: rtl/pll_reset_ctrl_lock_sync.sv
// Multi-flop synchronizer bringing the PLL locked flag into the refclk domain.
module pll_lock_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic refclk,
   input  logic rst_n,
   input  logic i_locked,
   output logic o_locked_s
);
   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_locked};
   end

   assign o_locked_s = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock sequencer: pulses pll_rst, qualifies lock, releases sys_rst_n.
// Define PLL_RST_CTRL_LOSS_COUNT_EN to add the saturating loss_count output.
module pll_reset_ctrl
   import pll_rst_ctrl_pkg::*;
#(
   parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int MAX_RETRY        = DEF_MAX_RETRY,
   parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
   input logic             refclk,
   input logic             rst_n,
   pll_reset_ctrl_if.slave bus
);
   localparam int PW = cnt_w(RST_PULSE_CYC);
   localparam int SW = cnt_w(LOCK_STABLE_CYC);
   localparam int CW = (PW > SW) ? PW : SW;
   localparam int TW = cnt_w(LOCK_TIMEOUT_CYC);
   localparam int RW = cnt_w(MAX_RETRY);

   pll_rst_state_t r_state, w_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic [TW-1:0]  r_tmo, w_tmo_nxt;
   logic [RW-1:0]  r_retry, w_retry_nxt, w_retry_inc;
   logic           w_locked_s, w_tmo_hit, w_loss;
   logic           r_pll_rst, r_sys_rst_n, r_ready, r_lock_lost, r_fail;

   pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .i_locked  (bus.pll_locked_in),
      .o_locked_s(w_locked_s)
   );

   assign w_tmo_hit   = (r_tmo == TW'(LOCK_TIMEOUT_CYC - 1));
   assign w_retry_inc = r_retry + RW'(1);

   always_comb begin
      w_nxt       = r_state;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_retry_nxt = r_retry;
      w_loss      = 1'b0;
      case (r_state)
         RESET_PLL: begin
            if (r_cnt == CW'(RST_PULSE_CYC - 1)) begin
               w_nxt     = WAIT_LOCK;
               w_cnt_nxt = '0;
               w_tmo_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         WAIT_LOCK, STABLE: begin
            // Completion beats timeout; timeout beats a lock drop.
            if (r_state == STABLE && w_locked_s && r_cnt == CW'(LOCK_STABLE_CYC - 1)) begin
               w_nxt     = RUN;
               w_cnt_nxt = '0;
            end else if (w_tmo_hit) begin
               w_retry_nxt = w_retry_inc;
               w_cnt_nxt   = '0;
               w_nxt       = (w_retry_inc == RW'(MAX_RETRY)) ? FAIL : RESET_PLL;
            end else begin
               w_tmo_nxt = r_tmo + TW'(1);
               if (!w_locked_s) begin
                  w_nxt     = WAIT_LOCK;
                  w_cnt_nxt = '0;
               end else if (r_state == WAIT_LOCK) begin
                  w_nxt     = STABLE;
                  w_cnt_nxt = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         RUN: begin
            if (!w_locked_s) begin
               w_nxt       = RESET_PLL;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
               w_loss      = 1'b1;
            end
         end
         FAIL:    w_nxt = FAIL;
         default: w_nxt = RESET_PLL;
      endcase
      if (bus.soft_rst_req) begin
         w_nxt       = RESET_PLL;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
         w_loss      = 1'b0;
      end
   end

   // Outputs decode the next state so they move on the first cycle of a state.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RESET_PLL;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_retry     <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_rst_n <= 1'b0;
         r_ready     <= 1'b0;
         r_lock_lost <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tmo       <= w_tmo_nxt;
         r_retry     <= w_retry_nxt;
         r_pll_rst   <= (w_nxt == RESET_PLL);
         r_sys_rst_n <= (w_nxt == RUN);
         r_ready     <= (w_nxt == RUN);
         r_lock_lost <= w_loss;
         r_fail      <= (w_nxt == FAIL);
      end
   end

   assign bus.pll_rst   = r_pll_rst;
   assign bus.sys_rst_n = r_sys_rst_n;
   assign bus.ready     = r_ready;
   assign bus.lock_lost = r_lock_lost;
   assign bus.fail      = r_fail;
   assign bus.retry_cnt = r_retry;

`ifdef PLL_RST_CTRL_LOSS_COUNT_EN
   logic [LOSS_CNT_W-1:0] r_loss_cnt;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)                          r_loss_cnt <= '0;
      else if (w_loss && r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
   end

   assign bus.loss_count = r_loss_cnt;
`endif
endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset and lock sequencer for the fabric PLL wrapper. It drives the PLL reset input, synchronizes and qualifies the PLL `locked` output, and holds the downstream system reset until lock has been stable for a programmed time. It re-sequences the PLL on lock loss, retries on lock timeout, and reports a sticky failure after a bounded number of retries. It sits between board reset / software reset sources and the PLL plus its clock consumers.

## Interface
Parameters:
- `RST_PULSE_CYC`, 16: `pll_rst` high time per reset attempt, in `refclk` cycles (≥1).
- `LOCK_STABLE_CYC`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYC`, 50000: WAIT_LOCK+STABLE budget per attempt, 1 ms at 50 MHz (≥1).
- `MAX_RETRY`, 3: timeouts tolerated before FAIL (≥1).
- `SYNC_STAGES`, 2: flops in the `pll_locked_in` synchronizer (≥2).

Ports:
- `refclk` in 1: sole clock, free-running PLL reference.
- `rst_n` in 1: reset, asynchronous, active-low.
- `soft_rst_req` in 1: synchronous request to restart sequencing; level sampled each edge.
- `pll_locked_in` in 1: PLL `locked`, asynchronous to `refclk`.
- `pll_rst` out 1: PLL reset, active-high.
- `sys_rst_n` out 1: downstream reset, active-low; high only in RUN.
- `ready` out 1: high only in RUN.
- `lock_lost` out 1: one-cycle pulse on lock loss in RUN.
- `fail` out 1: sticky; set on entry to FAIL.
- `retry_cnt` out $clog2(MAX_RETRY+1): timeouts in the current sequence.

## Operation
- States:
  - RESET_PLL: `pll_rst`=1; after `RST_PULSE_CYC` cycles → WAIT_LOCK.
  - WAIT_LOCK: `locked_s`=1 → STABLE.
  - STABLE: `locked_s` high for `LOCK_STABLE_CYC` consecutive cycles → RUN. If `locked_s` drops → WAIT_LOCK; the stable count clears and `retry_cnt` is unchanged.
  - RUN: `locked_s`=0 → RESET_PLL, pulse `lock_lost`, clear `retry_cnt`.
  - FAIL: `pll_rst`=0, `fail`=1. Exits only on `soft_rst_req` or `rst_n`.
- Timeout counter:
  - Clears on WAIT_LOCK entry from RESET_PLL.
  - Runs through WAIT_LOCK and STABLE. It does not clear on a STABLE→WAIT_LOCK bounce, so lock flapping is bounded.
  - Reaching `LOCK_TIMEOUT_CYC` increments `retry_cnt`. If the new value equals `MAX_RETRY` → FAIL, else → RESET_PLL.
- `soft_rst_req`=1 in any state → RESET_PLL next cycle and clears `retry_cnt` and `fail`. Priority is `soft_rst_req` > timeout > lock events.
- If timeout and STABLE completion coincide, completion wins (→ RUN).
- All counters are sized $clog2(max value + 1) and never wrap; each clears on state entry.

## Timing
- Reset values:
  - State RESET_PLL with counter 0.
  - Outputs: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `lock_lost`=0, `fail`=0, `retry_cnt`=0.
  - `rst_n` assertion forces these values asynchronously, including mid-operation.
- All outputs are registered and decoded from next state, so they change on the first cycle of the new state.
- `pll_rst` is high for exactly `RST_PULSE_CYC` cycles per attempt.
- Lock release latency:
  - Sync: `pll_locked_in` reaches `locked_s` after `SYNC_STAGES` edges.
  - Transition: WAIT_LOCK→STABLE takes 1 cycle.
  - Release: `ready` and `sys_rst_n` rise `SYNC_STAGES`+`LOCK_STABLE_CYC`+1 cycles after `pll_locked_in` rises.
- Lock loss in RUN: `lock_lost`=1, `ready`=0, `sys_rst_n`=0 and `pll_rst`=1 all occur `SYNC_STAGES`+1 cycles after `pll_locked_in` falls.
- `sys_rst_n` deassertion is synchronous to `refclk`; `outclk_*` domains re-synchronize it locally.

## Configuration
- `PLL_RST_CTRL_LOSS_COUNT_EN` defined:
  - Adds output `loss_count` [15:0], a saturating count of `lock_lost` pulses.
  - Cleared by `rst_n` only, not by `soft_rst_req`.
- Undefined: no port and no logic.

## Structure
- `pll_rst_ctrl_pkg`:
  - State enum `pll_rst_state_t` (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL).
  - Default parameter constants.
  - Loss-count width constant.
- Sub-module `pll_lock_sync`: `SYNC_STAGES`-deep flop chain, reset to 0 by `rst_n`, output `locked_s`.

## Test plan
Bench parameters: `RST_PULSE_CYC`=4, `LOCK_STABLE_CYC`=8, `LOCK_TIMEOUT_CYC`=32, `MAX_RETRY`=2, `SYNC_STAGES`=2.
- Nominal: release `rst_n`, raise `pll_locked_in` 10 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles; `ready`/`sys_rst_n` rise 11 cycles after `pll_locked_in`; `retry_cnt`=0.
- Glitch: drop `pll_locked_in` for 1 cycle after 5 STABLE cycles → stable count restarts, `ready` delayed accordingly, `retry_cnt` stays 0, no `pll_rst` pulse.
- Timeout: hold `pll_locked_in`=0 → `pll_rst` re-pulses 32 cycles after WAIT_LOCK entry with `retry_cnt`=1; after the second timeout `fail`=1, `pll_rst`=0, `retry_cnt`=2, state holds.
- Lock loss: drop `pll_locked_in` in RUN → 3 cycles later `lock_lost` pulses 1 cycle, `sys_rst_n`=0, `pll_rst` high 4 cycles; relock then reaches RUN again. With the macro, `loss_count`=1.
- Soft reset: `soft_rst_req` 1 cycle while in FAIL → next cycle `fail`=0, `retry_cnt`=0, `pll_rst`=1. Repeat in RUN → `sys_rst_n`=0 next cycle.
- Async reset: assert `rst_n` mid-STABLE between edges → all outputs take reset values immediately; sequencing restarts cleanly on release.
